alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares one combinational `alu` instance (in1/in2 signed WIDTH, op[3:0], nvalid_data, out 2*WIDTH, zero, error) between two requesters. It arbitrates round-robin, latches the winner's operands and drives the ALU for LATENCY settle cycles. It then captures the result and returns it on a valid/ready response channel tagged with the requester id. It sits between client blocks and the ALU; the ALU itself is instantiated outside and wired to the alu_* ports.

Parameters:
WIDTH, 8, operand width; result width is 2*WIDTH
LATENCY, 1, cycles operands are held on the ALU before sampling (legal range >= 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  2  per-requester request valid, bit i = requester i
req_ready  output  2  per-requester accept; at most one bit high
req_in1  input  2*WIDTH  packed {req1_in1, req0_in1}, signed
req_in2  input  2*WIDTH  packed {req1_in2, req0_in2}, signed
req_op  input  8  packed {req1_op, req0_op}; 0 add, 2 sub, 4 mul, 8 div
alu_in1  output  WIDTH  latched operand 1 to ALU
alu_in2  output  WIDTH  latched operand 2 to ALU
alu_op  output  4  latched opcode to ALU
alu_nvalid_data  output  1  low only while the ALU is executing
alu_out  input  2*WIDTH  ALU result, signed
alu_zero  input  1  ALU zero flag
alu_error  input  1  ALU error flag (division by zero)
rsp_valid  output  1  response valid
rsp_ready  input  1  response accepted by consumer
rsp_id  output  1  requester that owns the response
rsp_out  output  2*WIDTH  captured result, signed
rsp_zero  output  1  captured zero flag
rsp_error  output  1  captured error flag, or illegal-op error

Behaviour:
- Reset (async assert, sync release): state IDLE; last_grant=1 (requester 0 wins first); alu_in1/in2/op=0; alu_nvalid_data=1; rsp_valid/id/out/zero/error=0; counter=0.
- req_ready is combinational: high only for the granted bit, and only while state==IDLE. Handshake is req_valid[i] & req_ready[i] at a rising edge.
- Grant in IDLE:
  - One valid: grant it.
  - Both valid: grant the one != last_grant.
  - None valid: stay IDLE.
- On accept: latch in1/in2/op and id; set last_grant=id.
- FSM transitions:
  - IDLE -> EXEC on accept with legal op (0, 2, 4, 8). Counter loads LATENCY-1.
  - IDLE -> RESP on accept with illegal op (any other value). rsp_out=0, rsp_zero=0, rsp_error=1. The ALU is never driven: alu_nvalid_data stays 1.
  - EXEC: alu_nvalid_data=0 and operands stable. Counter decrements each cycle. When the counter is 0, capture alu_out/zero/error into rsp_* and go to RESP.
  - RESP: rsp_valid=1; rsp_* held stable until rsp_valid & rsp_ready, then -> IDLE with rsp_valid cleared.
- Timing: accept at edge T; rsp_valid high from edge T+LATENCY to handshake. Illegal op: rsp_valid from edge T+1.
- Throughput: next accept no earlier than the cycle after the response handshake (min LATENCY+2 cycles/op).
- Requests arriving in EXEC/RESP are not accepted; requesters hold valid. No starvation: the loser of a tie wins the next arbitration.
- rsp_ready high while not in RESP: ignored.
- Reset mid-EXEC or mid-RESP: in-flight op dropped; all outputs return to reset values immediately.
- Arithmetic: the block passes data through unmodified; widths follow the ALU (out is 2*WIDTH signed).

Test Plan:
- Single add: req0 in1=3, in2=5, op=0, rsp_ready=1, LATENCY=1 -> req_ready[0] high in cycle 0; rsp_valid after edge 1 with id=0, out=8, zero=0, error=0.
- Tie and fairness: both valid continuously, req0 3-5 (op 2) and req1 3*5 (op 4) -> responses alternate id 0,1,0,1, with out=-2 and out=15.
- Division by zero: req1 in1=8, in2=0, op=8 -> rsp id=1, error=1. Also 8/2 -> out=4, error=0.
- Backpressure: rsp_ready held low 5 cycles after rsp_valid -> rsp_* stable; req_ready=0 throughout; completes on the first cycle rsp_ready=1.
- Illegal op 3 and sign check: op=3 -> rsp_valid the next cycle with error=1, out=0, alu_nvalid_data never low. Then WIDTH=8 in1=129 (-127), in2=-129 (127), op=4 -> out=-16129.
- Reset mid-op: LATENCY=4, assert rst_n=0 during EXEC -> rsp_valid=0, alu_nvalid_data=1 at once. After release, both valid -> requester 0 granted first.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin front end that time-shares one external ALU between two
// requesters and returns each result on a tagged valid/ready channel.
module alu_arbiter #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_in1,
  input  logic [2*WIDTH-1:0] req_in2,
  input  logic [7:0]         req_op,
  output logic [WIDTH-1:0]   alu_in1,
  output logic [WIDTH-1:0]   alu_in2,
  output logic [3:0]         alu_op,
  output logic               alu_nvalid_data,
  input  logic [2*WIDTH-1:0] alu_out,
  input  logic               alu_zero,
  input  logic               alu_error,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_out,
  output logic               rsp_zero,
  output logic               rsp_error
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            last_grant;
  logic [CW-1:0]   cnt;
  logic            gid;
  logic            accept;
  logic            legal;
  logic            cnt_done;
  logic [WIDTH-1:0] sel_in1;
  logic [WIDTH-1:0] sel_in2;
  logic [3:0]      sel_op;

  // A tie goes to whoever did not win last time.
  always_comb begin
    gid = req_valid[1];
    if (&req_valid) gid = ~last_grant;
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && |req_valid) req_ready[gid] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  assign sel_in1 = gid ? req_in1[2*WIDTH-1:WIDTH] : req_in1[WIDTH-1:0];
  assign sel_in2 = gid ? req_in2[2*WIDTH-1:WIDTH] : req_in2[WIDTH-1:0];
  assign sel_op  = gid ? req_op[7:4] : req_op[3:0];

  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      sel_op == 4'd0: legal = 1'b1;
      sel_op == 4'd2: legal = 1'b1;
      sel_op == 4'd4: legal = 1'b1;
      sel_op == 4'd8: legal = 1'b1;
      default:        legal = 1'b0;
    endcase
  end

  assign cnt_done = (cnt == '0);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = legal ? EXEC : RESP;
      EXEC: if (cnt_done) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign alu_nvalid_data = (state != EXEC);
  assign rsp_valid       = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      cnt        <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_op     <= '0;
      rsp_id     <= 1'b0;
      rsp_out    <= '0;
      rsp_zero   <= 1'b0;
      rsp_error  <= 1'b0;
    end else begin
      if (accept) begin
        alu_in1    <= sel_in1;
        alu_in2    <= sel_in2;
        alu_op     <= sel_op;
        rsp_id     <= gid;
        last_grant <= gid;
        cnt        <= CW'(LATENCY - 1);
        // Illegal opcodes never reach the ALU; answer straight away.
        if (!legal) begin
          rsp_out   <= '0;
          rsp_zero  <= 1'b0;
          rsp_error <= 1'b1;
        end
      end
      if (state == EXEC) begin
        if (cnt_done) begin
          rsp_out   <= alu_out;
          rsp_zero  <= alu_zero;
          rsp_error <= alu_error;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: two instances (LATENCY 1 and 4),
// each wired to a behavioural ALU.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0]  a_req_valid, a_req_ready;
  logic [15:0] a_req_in1, a_req_in2;
  logic [7:0]  a_req_op;
  logic [7:0]  a_alu_in1, a_alu_in2;
  logic [3:0]  a_alu_op;
  logic        a_alu_nv;
  logic [15:0] a_alu_out;
  logic        a_alu_zero, a_alu_error;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_id;
  logic [15:0] a_rsp_out;
  logic        a_rsp_zero, a_rsp_error;

  logic [1:0]  b_req_valid, b_req_ready;
  logic [15:0] b_req_in1, b_req_in2;
  logic [7:0]  b_req_op;
  logic [7:0]  b_alu_in1, b_alu_in2;
  logic [3:0]  b_alu_op;
  logic        b_alu_nv;
  logic [15:0] b_alu_out;
  logic        b_alu_zero, b_alu_error;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_id;
  logic [15:0] b_rsp_out;
  logic        b_rsp_zero, b_rsp_error;

  function automatic logic [17:0] alu_f(input logic [7:0] a,
                                        input logic [7:0] b,
                                        input logic [3:0] op,
                                        input logic nv);
    logic signed [15:0] sa, sb, r;
    logic err;
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    r = '0;
    err = 1'b0;
    if (!nv) begin
      case (op)
        4'd0: r = sa + sb;
        4'd2: r = sa - sb;
        4'd4: r = sa * sb;
        4'd8: if (b == 8'd0) err = 1'b1; else r = sa / sb;
        default: r = '0;
      endcase
    end
    return {err, (r == 16'sd0), r};
  endfunction

  always_comb {a_alu_error, a_alu_zero, a_alu_out} =
    alu_f(a_alu_in1, a_alu_in2, a_alu_op, a_alu_nv);
  always_comb {b_alu_error, b_alu_zero, b_alu_out} =
    alu_f(b_alu_in1, b_alu_in2, b_alu_op, b_alu_nv);

  alu_arbiter #(.WIDTH(8), .LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_in1(a_req_in1), .req_in2(a_req_in2), .req_op(a_req_op),
    .alu_in1(a_alu_in1), .alu_in2(a_alu_in2), .alu_op(a_alu_op),
    .alu_nvalid_data(a_alu_nv), .alu_out(a_alu_out),
    .alu_zero(a_alu_zero), .alu_error(a_alu_error),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_id(a_rsp_id), .rsp_out(a_rsp_out),
    .rsp_zero(a_rsp_zero), .rsp_error(a_rsp_error)
  );

  alu_arbiter #(.WIDTH(8), .LATENCY(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_in1(b_req_in1), .req_in2(b_req_in2), .req_op(b_req_op),
    .alu_in1(b_alu_in1), .alu_in2(b_alu_in2), .alu_op(b_alu_op),
    .alu_nvalid_data(b_alu_nv), .alu_out(b_alu_out),
    .alu_zero(b_alu_zero), .alu_error(b_alu_error),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_id(b_rsp_id), .rsp_out(b_rsp_out),
    .rsp_zero(b_rsp_zero), .rsp_error(b_rsp_error)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_a(input int maxc);
    int n;
    n = 0;
    while (a_rsp_valid !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    chk("a_rsp_timeout", 16'(a_rsp_valid), 16'd1);
  endtask

  task automatic wait_b(input int maxc);
    int n;
    n = 0;
    while (b_rsp_valid !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    chk("b_rsp_timeout", 16'(b_rsp_valid), 16'd1);
  endtask

  initial begin
    a_req_valid = '0; a_req_in1 = '0; a_req_in2 = '0; a_req_op = '0;
    a_rsp_ready = 1'b0;
    b_req_valid = '0; b_req_in1 = '0; b_req_in2 = '0; b_req_op = '0;
    b_rsp_ready = 1'b0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 16'(a_rsp_valid), 16'd0);
    chk("rst_alu_nv", 16'(a_alu_nv), 16'd1);
    chk("rst_alu_op", 16'(a_alu_op), 16'd0);
    chk("rst_alu_in1", 16'(a_alu_in1), 16'd0);
    chk("rst_rsp_out", a_rsp_out, 16'd0);
    chk("rst_rsp_error", 16'(a_rsp_error), 16'd0);
    chk("rst_b_nv", 16'(b_alu_nv), 16'd1);
    rst_n = 1'b1;
    tick();

    // single add 3+5
    a_req_in1 = 16'h0003; a_req_in2 = 16'h0005; a_req_op = 8'h00;
    a_req_valid = 2'b01; a_rsp_ready = 1'b1;
    #1;
    chk("add_req_ready", 16'(a_req_ready), 16'd1);
    tick();
    a_req_valid = 2'b00;
    chk("add_exec_nv", 16'(a_alu_nv), 16'd0);
    chk("add_alu_in1", 16'(a_alu_in1), 16'd3);
    chk("add_early_valid", 16'(a_rsp_valid), 16'd0);
    tick();
    chk("add_rsp_valid", 16'(a_rsp_valid), 16'd1);
    chk("add_rsp_id", 16'(a_rsp_id), 16'd0);
    chk("add_rsp_out", a_rsp_out, 16'd8);
    chk("add_rsp_zero", 16'(a_rsp_zero), 16'd0);
    chk("add_rsp_error", 16'(a_rsp_error), 16'd0);
    tick();
    chk("add_done", 16'(a_rsp_valid), 16'd0);

    // tie and fairness after a fresh reset
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    a_req_in1 = {8'd3, 8'd3}; a_req_in2 = {8'd5, 8'd5};
    a_req_op = {4'd4, 4'd2};
    a_req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_a(10);
      chk("tie_id", 16'(a_rsp_id), 16'(k % 2));
      chk("tie_out", a_rsp_out, (k % 2 == 1) ? 16'd15 : 16'hFFFE);
      tick();
    end
    a_req_valid = 2'b00;

    // division by zero, then 8/2
    a_req_in1 = {8'd8, 8'd0}; a_req_in2 = {8'd0, 8'd0};
    a_req_op = {4'd8, 4'd0};
    a_req_valid = 2'b10;
    #1;
    chk("div_req_ready", 16'(a_req_ready), 16'd2);
    tick();
    a_req_valid = 2'b00;
    wait_a(5);
    chk("div0_id", 16'(a_rsp_id), 16'd1);
    chk("div0_error", 16'(a_rsp_error), 16'd1);
    tick();
    a_req_in2 = {8'd2, 8'd0};
    a_req_valid = 2'b10;
    tick();
    a_req_valid = 2'b00;
    wait_a(5);
    chk("div_id", 16'(a_rsp_id), 16'd1);
    chk("div_out", a_rsp_out, 16'd4);
    chk("div_error", 16'(a_rsp_error), 16'd0);
    tick();

    // backpressure: 100+27 held for 5 cycles
    a_rsp_ready = 1'b0;
    a_req_in1 = 16'h0064; a_req_in2 = 16'h001B; a_req_op = 8'h00;
    a_req_valid = 2'b01;
    tick();
    wait_a(5);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 16'(a_rsp_valid), 16'd1);
      chk("bp_out", a_rsp_out, 16'd127);
      chk("bp_req_ready", 16'(a_req_ready), 16'd0);
      tick();
    end
    a_rsp_ready = 1'b1;
    a_req_valid = 2'b00;
    chk("bp_last_valid", 16'(a_rsp_valid), 16'd1);
    tick();
    chk("bp_done", 16'(a_rsp_valid), 16'd0);

    // illegal opcode 3
    a_req_in1 = 16'h0005; a_req_in2 = 16'h0006; a_req_op = 8'h03;
    a_req_valid = 2'b01;
    #1;
    chk("ill_req_ready", 16'(a_req_ready), 16'd1);
    tick();
    a_req_valid = 2'b00;
    chk("ill_valid", 16'(a_rsp_valid), 16'd1);
    chk("ill_error", 16'(a_rsp_error), 16'd1);
    chk("ill_out", a_rsp_out, 16'd0);
    chk("ill_nv", 16'(a_alu_nv), 16'd1);
    tick();
    chk("ill_done", 16'(a_rsp_valid), 16'd0);

    // signed multiply -127 * 127
    a_req_in1 = 16'h0081; a_req_in2 = 16'h007F; a_req_op = 8'h04;
    a_req_valid = 2'b01;
    tick();
    a_req_valid = 2'b00;
    chk("mul_alu_in1", 16'(a_alu_in1), 16'h0081);
    wait_a(5);
    chk("mul_out", a_rsp_out, 16'hC0FF);
    chk("mul_zero", 16'(a_rsp_zero), 16'd0);
    tick();

    // LATENCY=4 timing: 1+2
    b_rsp_ready = 1'b1;
    b_req_in1 = 16'h0001; b_req_in2 = 16'h0002; b_req_op = 8'h00;
    b_req_valid = 2'b01;
    tick();
    b_req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk("l4_wait_valid", 16'(b_rsp_valid), 16'd0);
      chk("l4_wait_nv", 16'(b_alu_nv), 16'd0);
      tick();
    end
    chk("l4_valid", 16'(b_rsp_valid), 16'd1);
    chk("l4_out", b_rsp_out, 16'd3);
    tick();

    // reset mid-EXEC on requester 0, then tie must go to requester 0
    b_req_in1 = 16'h0009;
    b_req_valid = 2'b01;
    tick();
    b_req_valid = 2'b00;
    tick();
    chk("mid_exec_nv", 16'(b_alu_nv), 16'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 16'(b_rsp_valid), 16'd0);
    chk("mid_rst_nv", 16'(b_alu_nv), 16'd1);
    chk("mid_rst_in1", 16'(b_alu_in1), 16'd0);
    chk("mid_rst_op", 16'(b_alu_op), 16'd0);
    tick();
    rst_n = 1'b1;
    b_req_in1 = {8'd20, 8'd10}; b_req_in2 = {8'd0, 8'd2};
    b_req_op = 8'h00;
    b_req_valid = 2'b11;
    #1;
    chk("post_rst_grant", 16'(b_req_ready), 16'd1);
    tick();
    b_req_valid = 2'b00;
    chk("post_rst_in1", 16'(b_alu_in1), 16'd10);
    wait_b(8);
    chk("post_rst_id", 16'(b_rsp_id), 16'd0);
    chk("post_rst_out", b_rsp_out, 16'd12);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
